mem_arbiter: RTL and testbench



---
 rtl/mem_pkg.sv | 21 ++
 rtl/lpm_ram_dq.sv | 31 +++
 rtl/mem_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the instruction/data memory arbiter.
package mem_pkg;

    typedef logic [31:0] mem_word_t;

    typedef enum logic {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } arb_state_e;

    // Byte-lane merge for read-modify-write: strobed lanes take the new word.
    function automatic mem_word_t merge_bytes(mem_word_t old_word, mem_word_t new_word,
                                              logic [3:0] strb);
        mem_word_t res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = strb[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/lpm_ram_dq.sv
// Behavioural stand-in for the single-port synchronous-read lpm_ram_dq
// primitive: write on inclock, registered read data on outclock.
// Image loading from LPM_FILE is left to the vendor primitive.
module lpm_ram_dq #(
    parameter int LPM_WIDTH   = 32,
    parameter int LPM_WIDTHAD = 8,
    parameter     LPM_FILE    = "UNUSED"
) (
    input  logic [LPM_WIDTH-1:0]   data,
    input  logic [LPM_WIDTHAD-1:0] address,
    input  logic                   we,
    input  logic                   inclock,
    input  logic                   outclock,
    output logic [LPM_WIDTH-1:0]   q
);

    logic [LPM_WIDTH-1:0] mem [2**LPM_WIDTHAD];

    // Write port.
    always_ff @(posedge inclock) begin
        if (we) begin
            mem[address] <= data;
        end
    end

    // Synchronous read; a same-cycle write returns the old word.
    always_ff @(posedge outclock) begin
        q <= mem[address];
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port RAM between instruction fetch and load/store.
// Data wins unless fetch has been starved for STARVE_LIMIT data grants.
// Optional macro MEM_ARBITER_SUBWORD_EN: partial-strobe stores become a
// two-cycle read-modify-write; without it every store writes the full word.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W       = 8,
    parameter     INIT_FILE    = "mem.hex",
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_rsp_valid,
    output logic [31:0]       if_rsp_data,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic              d_req_we,
    input  logic [31:0]       d_req_wdata,
    input  logic [3:0]        d_req_wstrb,
    output logic              d_rsp_valid,
    output logic [31:0]       d_rsp_rdata
);

    localparam int               CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              if_vld_q, if_vld_d;
    logic              d_vld_q, d_vld_d;
    logic              gnt_d, gnt_if;
    logic              in_idle;
    logic              start_rmw;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    mem_word_t         ram_wdata, ram_q;

`ifdef MEM_ARBITER_SUBWORD_EN
    arb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    mem_word_t         wdata_q, wdata_d;
    logic [3:0]        strb_q, strb_d;

    assign in_idle   = (state_q == IDLE);
    assign start_rmw = gnt_d && d_req_we && (d_req_wstrb != 4'hF);
`else
    logic unused_wstrb;

    assign in_idle      = 1'b1;
    assign start_rmw    = 1'b0;
    assign unused_wstrb = ^d_req_wstrb;
`endif

    // Grant: data first while under the starvation limit, then fetch, then data.
    always_comb begin
        gnt_d  = 1'b0;
        gnt_if = 1'b0;
        if (!rst && in_idle) begin
            if (d_req_valid && (cnt_q < LIMIT)) begin
                gnt_d = 1'b1;
            end else if (if_req_valid) begin
                gnt_if = 1'b1;
            end else if (d_req_valid) begin
                gnt_d = 1'b1;
            end
        end
    end

    // Starvation count: data grants while fetch waits, cleared when fetch is served or absent.
    always_comb begin
        cnt_d = cnt_q;
        if (!if_req_valid || gnt_if) begin
            cnt_d = '0;
        end else if (gnt_d && (cnt_q < LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Next state, RAM drive and response strobes.
    always_comb begin
        ram_addr  = d_req_addr;
        ram_we    = 1'b0;
        ram_wdata = d_req_wdata;
        if_vld_d  = gnt_if;
        d_vld_d   = 1'b0;
`ifdef MEM_ARBITER_SUBWORD_EN
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
`endif
        if (gnt_if) begin
            ram_addr = if_req_addr;
        end
        if (start_rmw) begin
`ifdef MEM_ARBITER_SUBWORD_EN
            state_d = RMW_WR;
            addr_d  = d_req_addr;
            wdata_d = d_req_wdata;
            strb_d  = d_req_wstrb;
`endif
        end else if (gnt_d) begin
            ram_we  = d_req_we;
            d_vld_d = 1'b1;
        end
`ifdef MEM_ARBITER_SUBWORD_EN
        if (state_q == RMW_WR) begin
            // RAM q holds the old word read in the accept cycle.
            ram_addr  = addr_q;
            ram_we    = !rst;
            ram_wdata = merge_bytes(ram_q, wdata_q, strb_q);
            d_vld_d   = 1'b1;
            state_d   = IDLE;
        end
`endif
    end

    // State, counter and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            if_vld_q <= 1'b0;
            d_vld_q  <= 1'b0;
`ifdef MEM_ARBITER_SUBWORD_EN
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            strb_q   <= '0;
`endif
        end else begin
            cnt_q    <= cnt_d;
            if_vld_q <= if_vld_d;
            d_vld_q  <= d_vld_d;
`ifdef MEM_ARBITER_SUBWORD_EN
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            strb_q   <= strb_d;
`endif
        end
    end

    lpm_ram_dq #(
        .LPM_WIDTH  (32),
        .LPM_WIDTHAD(ADDR_W),
        .LPM_FILE   (INIT_FILE)
    ) u_ram (
        .data    (ram_wdata),
        .address (ram_addr),
        .we      (ram_we),
        .inclock (clk),
        .outclock(clk),
        .q       (ram_q)
    );

    // A response pending when reset arrives is dropped, not delivered.
    assign if_req_ready = gnt_if;
    assign d_req_ready  = gnt_d;
    assign if_rsp_valid = if_vld_q && !rst;
    assign d_rsp_valid  = d_vld_q && !rst;
    assign if_rsp_data  = ram_q;
    assign d_rsp_rdata  = ram_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; expectations follow MEM_ARBITER_SUBWORD_EN.
module tb_mem_arbiter;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req_valid;
    logic              if_req_ready;
    logic [ADDR_W-1:0] if_req_addr;
    logic              if_rsp_valid;
    logic [31:0]       if_rsp_data;
    logic              d_req_valid;
    logic              d_req_ready;
    logic [ADDR_W-1:0] d_req_addr;
    logic              d_req_we;
    logic [31:0]       d_req_wdata;
    logic [3:0]        d_req_wstrb;
    logic              d_rsp_valid;
    logic [31:0]       d_rsp_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W      (ADDR_W),
        .INIT_FILE   ("mem.hex"),
        .STARVE_LIMIT(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req_valid(if_req_valid),
        .if_req_ready(if_req_ready),
        .if_req_addr (if_req_addr),
        .if_rsp_valid(if_rsp_valid),
        .if_rsp_data (if_rsp_data),
        .d_req_valid (d_req_valid),
        .d_req_ready (d_req_ready),
        .d_req_addr  (d_req_addr),
        .d_req_we    (d_req_we),
        .d_req_wdata (d_req_wdata),
        .d_req_wstrb (d_req_wstrb),
        .d_rsp_valid (d_rsp_valid),
        .d_rsp_rdata (d_rsp_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        if_req_valid = 1'b0;
        d_req_valid  = 1'b0;
        d_req_we     = 1'b0;
    endtask

    task automatic drive_store(input logic [ADDR_W-1:0] a, input logic [31:0] wd,
                               input logic [3:0] strb);
        d_req_valid = 1'b1;
        d_req_we    = 1'b1;
        d_req_addr  = a;
        d_req_wdata = wd;
        d_req_wstrb = strb;
    endtask

    // One fetch in cycle N, response checked in N+1.
    task automatic fetch_check(input string tag, input logic [ADDR_W-1:0] a,
                               input logic [31:0] exp);
        @(negedge clk);
        idle_inputs();
        if_req_valid = 1'b1;
        if_req_addr  = a;
        #1 chk({tag, "_ready"}, 32'(if_req_ready), 32'd1);
        @(negedge clk);
        idle_inputs();
        #1 chk({tag, "_vld"}, 32'(if_rsp_valid), 32'd1);
        chk({tag, "_data"}, if_rsp_data, exp);
    endtask

    // Both ports request every cycle; pat bit i = 1 means data granted in cycle i.
    task automatic contend(input string tag, input int n, input logic [7:0] pat);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            d_req_valid  = 1'b1;
            d_req_we     = 1'b0;
            d_req_addr   = 8'd5;
            if_req_valid = 1'b1;
            if_req_addr  = 8'd7;
            #1 chk({tag, "_d_rdy"}, 32'(d_req_ready), 32'(pat[i]));
            chk({tag, "_if_rdy"}, 32'(if_req_ready), 32'(!pat[i]));
            if (i > 0) chk({tag, "_if_rsp"}, 32'(if_rsp_valid), 32'(!pat[i-1]));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        if_req_addr = '0;
        d_req_addr  = '0;
        d_req_wdata = '0;
        d_req_wstrb = 4'hF;
        repeat (2) @(negedge clk);

        // Readies held low in reset even with both valids up.
        if_req_valid = 1'b1;
        d_req_valid  = 1'b1;
        #1 chk("rst_d_rdy", 32'(d_req_ready), 32'd0);
        chk("rst_if_rdy", 32'(if_req_ready), 32'd0);
        @(negedge clk);
        #1 chk("rst_if_rsp", 32'(if_rsp_valid), 32'd0);
        chk("rst_d_rsp", 32'(d_rsp_valid), 32'd0);
        idle_inputs();
        rst = 1'b0;

        // Back-to-back full stores: mem[5], then mem[7].
        @(negedge clk);
        drive_store(8'd5, 32'hDEADBEEF, 4'hF);
        #1 chk("st5_rdy", 32'(d_req_ready), 32'd1);
        @(negedge clk);
        drive_store(8'd7, 32'hAABBCCDD, 4'hF);
        #1 chk("st7_rdy", 32'(d_req_ready), 32'd1);
        chk("st5_rsp", 32'(d_rsp_valid), 32'd1);
        @(negedge clk);
        idle_inputs();
        #1 chk("st7_rsp", 32'(d_rsp_valid), 32'd1);

        fetch_check("fetch5", 8'd5, 32'hDEADBEEF);

        // Store then load of the same word in consecutive cycles.
        @(negedge clk);
        drive_store(8'd3, 32'h12345678, 4'hF);
        #1 chk("b2b_st_rdy", 32'(d_req_ready), 32'd1);
        @(negedge clk);
        d_req_we = 1'b0;
        #1 chk("b2b_ld_rdy", 32'(d_req_ready), 32'd1);
        chk("b2b_st_rsp", 32'(d_rsp_valid), 32'd1);
        @(negedge clk);
        idle_inputs();
        #1 chk("b2b_ld_rsp", 32'(d_rsp_valid), 32'd1);
        chk("b2b_ld_data", d_rsp_rdata, 32'h12345678);

        // Contention: d,d,d,d,if,d,d.
        contend("cont", 7, 8'b0110_1111);
        // Fetch absent for a cycle clears the count (was 2): four data grants again.
        @(negedge clk);
        if_req_valid = 1'b0;
        #1 chk("clr_d_rdy", 32'(d_req_ready), 32'd1);
        contend("cont2", 5, 8'b0000_1111);
        @(negedge clk);
        idle_inputs();
        #1 chk("cont2_if_rsp", 32'(if_rsp_valid), 32'd1);
        chk("cont2_if_data", if_rsp_data, 32'hAABBCCDD);

        // Fetch accepted just before reset gets no response.
        @(negedge clk);
        if_req_valid = 1'b1;
        if_req_addr  = 8'd5;
        #1 chk("prerst_rdy", 32'(if_req_ready), 32'd1);
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        #1 chk("prerst_no_rsp", 32'(if_rsp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Partial store 0x00001100, strobe 0010, to mem[7] = 0xAABBCCDD.
        @(negedge clk);
        drive_store(8'd7, 32'h00001100, 4'b0010);
        #1 chk("ps_rdy", 32'(d_req_ready), 32'd1);
`ifdef MEM_ARBITER_SUBWORD_EN
        @(negedge clk);
        d_req_we     = 1'b0;
        if_req_valid = 1'b1;
        #1 chk("ps_rmw_d_rdy", 32'(d_req_ready), 32'd0);
        chk("ps_rmw_if_rdy", 32'(if_req_ready), 32'd0);
        chk("ps_rmw_rsp", 32'(d_rsp_valid), 32'd0);
        @(negedge clk);
        idle_inputs();
        #1 chk("ps_rsp", 32'(d_rsp_valid), 32'd1);
        fetch_check("ps_read", 8'd7, 32'hAABB11DD);

        // Restore mem[7], then reset during RMW_WR.
        @(negedge clk);
        drive_store(8'd7, 32'hAABBCCDD, 4'hF);
        @(negedge clk);
        drive_store(8'd7, 32'h00001100, 4'b0010);
        #1 chk("rr_rdy", 32'(d_req_ready), 32'd1);
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1 chk("rr_no_rsp", 32'(d_rsp_valid), 32'd0);
        fetch_check("rr_read", 8'd7, 32'hAABBCCDD);
`else
        @(negedge clk);
        idle_inputs();
        #1 chk("ps_rsp", 32'(d_rsp_valid), 32'd1);
        fetch_check("ps_read", 8'd7, 32'h00001100);
`endif

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
